// File: rtl/div8_seq.sv
// div8_seq: sequential 8-bit unsigned restoring divider.
// It produces one quotient bit per clock, MSB first, and uses SUB8bit to form
// each trial difference. Requests are accepted through a start/busy/done
// handshake. Every output is driven straight from a register.

// SUB8bit: 8-bit subtractor. Borrow is the carry-out of A + ~B + 1, so
// Borrow = 1 means A >= B.
module SUB8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] S,
  output logic       Borrow
);
  logic [8:0] sum_s;

  assign sum_s  = {1'b0, A} + {1'b0, ~B} + 9'd1;
  assign S      = sum_s[7:0];
  assign Borrow = sum_s[8];
endmodule

module div8_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] Quotient,
  output logic [7:0] Remainder,
  output logic       DivByZero,
  output logic       busy,
  output logic       done
);
  // ZERO spends one cycle between the accept and DONE so that a divide-by-zero
  // reports done one cycle after it is accepted.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] dvd_q, dvd_d;
  logic [7:0] dvs_q, dvs_d;
  logic [7:0] r_q, r_d;
  logic [7:0] q_q, q_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] quot_q, quot_d;
  logic [7:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [7:0] shifted_s;
  logic       ovf_s;
  logic [7:0] diff_s;
  logic       borrow_s;
  logic       take_s;

  // Trial subtraction on the partial remainder after shifting in the next
  // dividend bit. ovf covers a partial remainder that needs 9 bits.
  assign shifted_s = {r_q[6:0], dvd_q[7]};
  assign ovf_s     = r_q[7];

  SUB8bit u_sub (
    .A      (shifted_s),
    .B      (dvs_q),
    .S      (diff_s),
    .Borrow (borrow_s)
  );

  assign take_s = ovf_s | borrow_s;

  // Next-state, datapath and output-register updates.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d = A;
          dvs_d = B;
          r_d   = 8'd0;
          q_d   = 8'd0;
          cnt_d = 3'd0;
          if (B == 8'd0) begin
            state_d = S_ZERO;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        r_d   = take_s ? diff_s : shifted_s;
        q_d   = {q_q[6:0], take_s};
        dvd_d = {dvd_q[6:0], 1'b0};
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
          quot_d  = {q_q[6:0], take_s};
          rem_d   = take_s ? diff_s : shifted_s;
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_ZERO: begin
        state_d = S_DONE;
        quot_d  = 8'hFF;
        rem_d   = dvd_q;
        dbz_d   = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= 8'd0;
      dvs_q   <= 8'd0;
      r_q     <= 8'd0;
      q_q     <= 8'd0;
      cnt_q   <= 3'd0;
      quot_q  <= 8'd0;
      rem_q   <= 8'd0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign DivByZero = dbz_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: a cycle-level reference model plus
// directed vectors with hand-computed results and a random sweep.
module tb_div8_seq;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       DivByZero;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_err;

  div8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. left counts the remaining busy cycles of an operation.
  // A division takes 9 busy cycles and a divide-by-zero takes 2. The results
  // appear with done in the final busy cycle, and start is ignored while busy.
  int         m_left;
  logic [7:0] m_pq, m_pr, m_q, m_r;
  logic       m_pz, m_z;

  // Advances the model on each clock and clears it on reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_q    <= 8'd0;
      m_r    <= 8'd0;
      m_z    <= 1'b0;
      m_pq   <= 8'd0;
      m_pr   <= 8'd0;
      m_pz   <= 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        if (B == 8'd0) begin
          m_left <= 2;
          m_pq   <= 8'hFF;
          m_pr   <= A;
          m_pz   <= 1'b1;
        end else begin
          m_left <= 9;
          m_pq   <= A / B;
          m_pr   <= A % B;
          m_pz   <= 1'b0;
        end
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_q <= m_pq;
        m_r <= m_pr;
        m_z <= m_pz;
      end
    end
  end

  // Compares the DUT against the model on every falling edge while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
      chk("done", {31'd0, done}, {31'd0, (m_left == 1)});
      chk("Quotient", {24'd0, Quotient}, {24'd0, m_q});
      chk("Remainder", {24'd0, Remainder}, {24'd0, m_r});
      chk("DivByZero", {31'd0, DivByZero}, {31'd0, m_z});
    end
  end

  // Runs one division. It can re-pulse start at the third sample or pull
  // rst_n low at the fifth sample. It checks the literal expectations, and
  // when rst_mid is set it checks that every output clears at once.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez,
                         input bit repulse, input bit rst_mid);
    int busy_n;
    int done_n;
    int done_at;
    bit ended;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    ended   = 1'b0;
    @(negedge clk);
    start = 1'b1;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    A     = 8'($urandom);
    B     = 8'($urandom);
    for (int k = 0; k < 20; k++) begin
      if (rst_mid && k == 4) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_Quotient", {24'd0, Quotient}, 32'd0);
        chk("rst_Remainder", {24'd0, Remainder}, 32'd0);
        chk("rst_DivByZero", {31'd0, DivByZero}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ended = 1'b1;
        break;
      end
      if (repulse && k == 2) begin
        start = 1'b1;
        A     = 8'd9;
        B     = 8'd9;
      end
      if (repulse && k == 3) begin
        start = 1'b0;
      end
      if (busy) busy_n = busy_n + 1;
      if (done) begin
        done_n = done_n + 1;
        if (done_at < 0) done_at = k;
      end
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ended) begin
      chk("busy_timeout", 32'd1, 32'd0);
    end else if (!rst_mid) begin
      chk("lit_Quotient", {24'd0, Quotient}, {24'd0, eq});
      chk("lit_Remainder", {24'd0, Remainder}, {24'd0, er});
      chk("lit_DivByZero", {31'd0, DivByZero}, {31'd0, ez});
      chk("lit_latency", done_at, (b == 8'd0) ? 32'd1 : 32'd8);
      chk("lit_busy_cycles", busy_n, (b == 8'd0) ? 32'd2 : 32'd9);
      chk("lit_done_pulses", done_n, 32'd1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A     = 8'd0;
    B     = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_Quotient", {24'd0, Quotient}, 32'd0);
    chk("reset_Remainder", {24'd0, Remainder}, 32'd0);
    chk("reset_DivByZero", {31'd0, DivByZero}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    #2 rst_n = 1'b1;

    run_div(8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 1'b0, 1'b0);
    run_div(8'd255, 8'd129, 8'd1,   8'd126, 1'b0, 1'b0, 1'b0);
    run_div(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0, 1'b0);
    run_div(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 1'b0, 1'b0);
    run_div(8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 1'b0, 1'b0);
    run_div(8'd13,  8'd0,   8'hFF,  8'd13,  1'b1, 1'b0, 1'b0);
    run_div(8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 1'b0, 1'b0);
    run_div(8'd100, 8'd3,   8'd33,  8'd1,   1'b0, 1'b1, 1'b0);
    run_div(8'd200, 8'd7,   8'd0,   8'd0,   1'b0, 1'b0, 1'b1);
    run_div(8'd50,  8'd6,   8'd8,   8'd2,   1'b0, 1'b0, 1'b0);
    run_div(8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 1'b0, 1'b0);
    run_div(8'd128, 8'd128, 8'd1,   8'd0,   1'b0, 1'b0, 1'b0);
    run_div(8'd254, 8'd128, 8'd1,   8'd126, 1'b0, 1'b0, 1'b0);

    // Random sweep with B biased towards 0 and large divisors.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      case (i % 4)
        0:       rb = 8'd0;
        1:       rb = 8'($urandom_range(128, 255));
        default: rb = 8'($urandom);
      endcase
      if (rb == 8'd0) begin
        run_div(ra, rb, 8'hFF, ra, 1'b1, 1'b0, 1'b0);
      end else begin
        run_div(ra, rb, ra / rb, ra % rb, 1'b0, 1'b0, 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Stops the run if the stimulus ever stalls.
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
